// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one async SRAM between instruction fetch and data port; RAM_ARB_RR_EN selects round-robin arbitration.
// Latency: read ack 3 cycles after the grant cycle, write ack 4 cycles; at least one IDLE cycle between transactions.
// Backpressure: requesters hold req until ack; stall_if/stall_mem flag a waiting port; arbitration happens only in IDLE.
module ram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [17:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [17:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic [17:0] RamAddr,
    inout  wire  [15:0] RamData,
    output logic        RamOE,
    output logic        RamWE,
    output logic        RamEN
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4,
        WR3  = 3'd5,
        ACK  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_owner_mem;
    logic [17:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_if_rdata;
    logic [15:0] r_mem_rdata;
    logic        r_if_ack;
    logic        r_mem_ack;
    logic        r_ram_en;
    logic        r_ram_oe;
    logic        r_ram_we;
    logic        r_drive;

    logic        w_grant;
    logic        w_grant_mem;
    logic        w_grant_we;

`ifdef RAM_ARB_RR_EN
    // Set when the most recent grant went to the data port; a tie goes to the other port.
    logic        r_last_mem;

    assign w_grant_mem = mem_req & (~if_req | ~r_last_mem);

    // Round-robin pointer: records the owner of every grant; starts at mem so the first tie goes to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_mem <= 1'b1;
        end else if (w_grant) begin
            r_last_mem <= w_grant_mem;
        end
    end
`else
    // Fixed priority: the data port always wins a tie.
    assign w_grant_mem = mem_req;
`endif

    assign w_grant    = (r_state == IDLE) & (if_req | mem_req);
    assign w_grant_we = w_grant_mem & mem_we;

    // Next-state logic; only IDLE looks at the requests.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (if_req | mem_req) w_next = w_grant_we ? WR1 : RD1;
            RD1:     w_next = RD2;
            RD2:     w_next = ACK;
            WR1:     w_next = WR2;
            WR2:     w_next = WR3;
            WR3:     w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the winning request so later changes on the ports are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_mem <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else if (w_grant) begin
            r_owner_mem <= w_grant_mem;
            r_addr      <= w_grant_mem ? mem_addr : if_addr;
            r_wdata     <= mem_wdata;
        end
    end

    // Strobes and acks are registered from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_en  <= 1'b1;
            r_ram_oe  <= 1'b1;
            r_ram_we  <= 1'b1;
            r_drive   <= 1'b0;
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
        end else begin
            r_ram_en  <= (w_next == IDLE) || (w_next == ACK);
            r_ram_oe  <= !((w_next == RD1) || (w_next == RD2));
            r_ram_we  <= (w_next != WR2);
            r_drive   <= (w_next == WR1) || (w_next == WR2) || (w_next == WR3);
            r_if_ack  <= (w_next == ACK) && !r_owner_mem;
            r_mem_ack <= (w_next == ACK) && r_owner_mem;
        end
    end

    // Capture SRAM read data at the end of RD2 into the owner's register; it holds until that owner's next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else if (r_state == RD2) begin
            if (r_owner_mem) begin
                r_mem_rdata <= RamData;
            end else begin
                r_if_rdata  <= RamData;
            end
        end
    end

    assign RamData   = r_drive ? r_wdata : 16'hzzzz;
    assign RamAddr   = r_addr;
    assign RamEN     = r_ram_en;
    assign RamOE     = r_ram_oe;
    assign RamWE     = r_ram_we;
    assign if_ack    = r_if_ack;
    assign mem_ack   = r_mem_ack;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign stall_if  = if_req & ~r_if_ack;
    assign stall_mem = mem_req & ~r_mem_ack;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: SRAM model on the bus, directed timing sequences, then random two-port traffic.
// Expected read data comes from a word-array reference memory; an ack monitor pops per-port expectation queues.
// Requesters hold req until their ack is seen, then drop it before the next rising edge.
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [17:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic [17:0] RamAddr;
    wire  [15:0] RamData;
    logic        RamOE;
    logic        RamWE;
    logic        RamEN;

    int          errors;
    int          checks;
    bit          mon_en;

    logic [15:0] sram    [0:1023];
    logic [15:0] ref_mem [0:1023];
    logic [15:0] exp_if_q[$];
    logic [15:0] exp_mem_q[$];
    logic [15:0] last_if_rd;
    logic [15:0] last_mem_rd;
    logic [15:0] mon_e;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .RamAddr(RamAddr), .RamData(RamData), .RamOE(RamOE), .RamWE(RamWE), .RamEN(RamEN)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] pat(input int i);
        logic [31:0] t;
        if (i == 16) return 16'h1234;
        t = (i * 32'h9E37) ^ 32'h5A5A;
        return t[15:0];
    endfunction

    // Asynchronous SRAM: drives the bus while selected for read, stores on a clock edge with WE low.
    assign RamData = (!RamEN && !RamOE) ? sram[RamAddr[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) sram[i] <= pat(i);
        end else if (!RamEN && !RamWE) begin
            sram[RamAddr[9:0]] <= RamData;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        last_if_rd  = 16'h0;
        last_mem_rd = 16'h0;
    endtask

    // Every ack carries the owner's rdata register: the new word for a read, the previous read for a write.
    task automatic push_exp(input bit pm, input bit we, input logic [17:0] a, input logic [15:0] d);
        if (pm) begin
            if (we) ref_mem[a[9:0]] = d;
            else    last_mem_rd = ref_mem[a[9:0]];
            exp_mem_q.push_back(last_mem_rd);
        end else begin
            last_if_rd = ref_mem[a[9:0]];
            exp_if_q.push_back(last_if_rd);
        end
    endtask

    // Ack monitor / scoreboard.
    always @(negedge clk) begin
        if (mon_en && (if_ack || mem_ack)) begin
            chk("ack exclusive", 32'(if_ack & mem_ack), 32'd0);
            if (if_ack) begin
                checks++;
                if (exp_if_q.size() == 0) begin
                    errors++;
                    $display("FAIL if_ack unexpected: ack seen, 0 pending transactions");
                end else begin
                    mon_e = exp_if_q.pop_front();
                    if (if_rdata !== mon_e) begin
                        errors++;
                        $display("FAIL if_rdata: got %0h, expected %0h", if_rdata, mon_e);
                    end
                end
            end
            if (mem_ack) begin
                checks++;
                if (exp_mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_ack unexpected: ack seen, 0 pending transactions");
                end else begin
                    mon_e = exp_mem_q.pop_front();
                    if (mem_rdata !== mon_e) begin
                        errors++;
                        $display("FAIL mem_rdata: got %0h, expected %0h", mem_rdata, mon_e);
                    end
                end
            end
        end
    end

    // Isolated transaction with cycle-exact bus checks; j counts cycles from the request cycle N.
    task automatic run_txn(input string tag, input bit pm, input bit we, input logic [17:0] a,
                           input logic [15:0] d, input int drop_at, input bit garble);
        int  lat;
        bit  rq;
        lat = we ? 4 : 3;
        @(negedge clk);
        if (pm) begin
            mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        push_exp(pm, we, a, d);
        for (int j = 0; j <= lat + 2; j++) begin
            if (j > 0) @(negedge clk);
            if (j == drop_at) begin
                if (pm) mem_req = 1'b0; else if_req = 1'b0;
            end
            if (garble && j == 1) begin
                mem_addr = ~a; mem_wdata = ~d; if_addr = ~a;
            end
            #1;
            rq = pm ? mem_req : if_req;
            chk($sformatf("%s own ack j%0d", tag, j), 32'(pm ? mem_ack : if_ack), 32'(j == lat));
            chk($sformatf("%s other ack j%0d", tag, j), 32'(pm ? if_ack : mem_ack), 32'd0);
            chk($sformatf("%s RamEN j%0d", tag, j), 32'(RamEN), 32'(!(j >= 1 && j < lat)));
            chk($sformatf("%s RamOE j%0d", tag, j), 32'(RamOE), 32'(!(!we && (j == 1 || j == 2))));
            chk($sformatf("%s RamWE j%0d", tag, j), 32'(RamWE), 32'(!(we && j == 2)));
            chk($sformatf("%s stall j%0d", tag, j), 32'(pm ? stall_mem : stall_if), 32'(rq && j != lat));
            if (j >= 1 && j < lat) chk($sformatf("%s RamAddr j%0d", tag, j), 32'(RamAddr), 32'(a));
            if (we && j >= 1 && j <= 3) chk($sformatf("%s RamData j%0d", tag, j), 32'(RamData), 32'(d));
            if (j == lat) begin
                if (pm) mem_req = 1'b0; else if_req = 1'b0;
            end
        end
    endtask

    task automatic if_master(input int n);
        for (int k = 0; k < n; k++) begin
            logic [17:0] a;
            int          t;
            a = 18'($urandom_range(0, 255));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            if_addr = a; if_req = 1'b1;
            push_exp(1'b0, 1'b0, a, 16'h0);
            t = 0;
            do begin
                @(negedge clk); #1; t++;
            end while (!if_ack && t < 60);
            chk("rnd if ack seen", 32'(if_ack), 32'd1);
            if_req = 1'b0;
        end
    endtask

    task automatic mem_master(input int n);
        for (int k = 0; k < n; k++) begin
            logic [17:0] a;
            logic [15:0] d;
            bit          w;
            int          t;
            a = 18'($urandom_range(512, 767));
            d = 16'($urandom);
            w = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            mem_addr = a; mem_wdata = d; mem_we = w; mem_req = 1'b1;
            push_exp(1'b1, w, a, d);
            t = 0;
            do begin
                @(negedge clk); #1; t++;
            end while (!mem_ack && t < 60);
            chk("rnd mem ack seen", 32'(mem_ack), 32'd1);
            mem_req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int ifc, memc;
        int acks[$];
        errors = 0; checks = 0; mon_en = 1'b0;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst RamEN", 32'(RamEN), 32'd1);
        chk("rst RamOE", 32'(RamOE), 32'd1);
        chk("rst RamWE", 32'(RamWE), 32'd1);
        chk("rst RamAddr", 32'(RamAddr), 32'd0);
        chk("rst if_ack", 32'(if_ack), 32'd0);
        chk("rst mem_ack", 32'(mem_ack), 32'd0);
        chk("rst if_rdata", 32'(if_rdata), 32'd0);
        chk("rst mem_rdata", 32'(mem_rdata), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Fetch read of a word holding 0x1234.
        run_txn("rd_if", 1'b0, 1'b0, 18'h00010, 16'h0, -1, 1'b0);
        // Data write with address/data changed after grant, then read back.
        run_txn("wr_mem", 1'b1, 1'b1, 18'h00020, 16'hBEEF, -1, 1'b1);
        run_txn("rd_mem", 1'b1, 1'b0, 18'h00020, 16'h0, -1, 1'b0);

        // Simultaneous reads from both ports.
        @(negedge clk);
        if_addr = 18'h30; mem_addr = 18'h40; mem_we = 1'b0;
        if_req = 1'b1; mem_req = 1'b1;
        push_exp(1'b0, 1'b0, 18'h30, 16'h0);
        push_exp(1'b1, 1'b0, 18'h40, 16'h0);
        ifc = -1; memc = -1;
        for (int j = 0; j <= 10; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            if (if_ack)  begin ifc = j;  if_req = 1'b0;  end
            if (mem_ack) begin memc = j; mem_req = 1'b0; end
        end
`ifdef RAM_ARB_RR_EN
        chk("tie if_ack cycle", 32'(ifc), 32'd3);
        chk("tie mem_ack cycle", 32'(memc), 32'd7);
`else
        chk("tie mem_ack cycle", 32'(memc), 32'd3);
        chk("tie if_ack cycle", 32'(ifc), 32'd7);
`endif

        // Fetch request held high across three transactions.
        @(negedge clk);
        if_addr = 18'h44; if_req = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(1'b0, 1'b0, 18'h44, 16'h0);
        for (int j = 0; j <= 13; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            if (if_ack) begin
                acks.push_back(j);
                if (acks.size() == 3) if_req = 1'b0;
            end
        end
        chk("held ack count", 32'(acks.size()), 32'd3);
        if (acks.size() == 3) begin
            chk("held ack 1", 32'(acks[0]), 32'd3);
            chk("held ack 2", 32'(acks[1]), 32'd7);
            chk("held ack 3", 32'(acks[2]), 32'd11);
        end

        // Data read whose request drops one cycle after grant.
        run_txn("drop_mem", 1'b1, 1'b0, 18'h00050, 16'h0, 1, 1'b0);

        // Reset in the middle of a write (during WR2).
        @(negedge clk);
        mem_addr = 18'h3F0; mem_wdata = 16'hA5A5; mem_we = 1'b1; mem_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; mem_req = 1'b0;
        @(negedge clk);
        #1;
        chk("abort RamWE", 32'(RamWE), 32'd1);
        chk("abort RamEN", 32'(RamEN), 32'd1);
        chk("abort RamOE", 32'(RamOE), 32'd1);
        chk("abort mem_ack", 32'(mem_ack), 32'd0);
        chk("abort RamAddr", 32'(RamAddr), 32'd0);
        chk("abort if_rdata", 32'(if_rdata), 32'd0);
        chk("abort mem_rdata", 32'(mem_rdata), 32'd0);
        rst = 1'b0;
        model_reset();
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("abort idle mem_ack %0d", j), 32'(mem_ack), 32'd0);
            chk($sformatf("abort idle RamEN %0d", j), 32'(RamEN), 32'd1);
        end
        run_txn("post_rst", 1'b1, 1'b0, 18'h003F0, 16'h0, -1, 1'b0);

        // Random concurrent traffic on both ports.
        fork
            if_master(40);
            mem_master(40);
        join
        repeat (6) @(negedge clk);
        chk("if queue drained", 32'(exp_if_q.size()), 32'd0);
        chk("mem queue drained", 32'(exp_mem_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
